// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared state encoding and frame constants for the UART TX path
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Transmitter FSM states; the encoding is fixed so that state values are stable
  // across builds and debug views.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Frame format is 8N1.
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_fifo_drain_baud_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : baud_tick_gen
// Description : Bit-period counter; tick marks the last clock of each bit
// Revision    : 1.0 - initial release
// ============================================================================
module baud_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int c_CW = $clog2(DIV);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(DIV - 1);

  logic [c_CW-1:0] r_count;

  // Count 0..DIV-1 while enabled; hold at zero when disabled or cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr || !en) begin
      r_count <= '0;
    end else if (r_count == c_LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign tick = en && (r_count == c_LAST);

endmodule : baud_tick_gen
`default_nettype wire

// File: rtl/uart_tx_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_drain
// Description : 8N1 UART transmitter draining a first-word-fall-through FIFO,
//               sending frames back-to-back while data is available
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] fifo_rdata,
  input  logic       fifo_empty,
  output logic       fifo_pop,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int c_DIV = CLK_HZ / BAUD;
  localparam int c_BW  = $clog2(DATA_BITS);
  localparam logic [c_BW-1:0] c_LAST_BIT = c_BW'(DATA_BITS - 1);

  generate
    if (c_DIV < 2) begin : g_div_check
      $error("uart_tx_fifo_drain: CLK_HZ/BAUD must be at least 2");
    end
  endgenerate

  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_BW-1:0] r_bit_idx;
  logic [c_BW-1:0] w_bit_idx_nxt;
  logic [7:0]      r_shift;
  logic [7:0]      w_shift_nxt;
  logic            w_tick;
  logic            w_load;
  logic            w_en;

  // The counter only runs while a frame is on the line and restarts at load.
  assign w_en = (r_state != IDLE);

  baud_tick_gen #(
    .DIV (c_DIV)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_load),
    .en   (w_en),
    .tick (w_tick)
  );

  // A byte is taken from the FIFO when idle, or in the final stop-bit cycle so the
  // next start bit follows without a gap. Held off during reset so no pop escapes.
  assign w_load = !rst && !fifo_empty &&
                  ((r_state == IDLE) || ((r_state == STOP) && w_tick));

  assign fifo_pop = w_load;

  // State, bit index and shift register update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  // Next-state logic and line outputs decoded from registered state.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    tx            = 1'b1;
    tx_busy       = 1'b1;
    tx_done       = 1'b0;

    case (r_state)
      IDLE: begin
        tx_busy = 1'b0;
        if (w_load) begin
          w_state_nxt = START;
          w_shift_nxt = fifo_rdata;
        end
      end

      START: begin
        tx = 1'b0;
        if (w_tick) begin
          w_state_nxt   = DATA;
          w_bit_idx_nxt = '0;
        end
      end

      DATA: begin
        tx = r_shift[0];
        if (w_tick) begin
          w_shift_nxt   = {1'b0, r_shift[7:1]};
          w_bit_idx_nxt = r_bit_idx + 1'b1;
          if (r_bit_idx == c_LAST_BIT) begin
            w_state_nxt = STOP;
          end
        end
      end

      STOP: begin
        tx      = 1'b1;
        tx_done = w_tick;
        if (w_tick) begin
          if (w_load) begin
            w_state_nxt = START;
            w_shift_nxt = fifo_rdata;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule : uart_tx_fifo_drain
`default_nettype wire

// File: tb/tb_uart_tx_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo_drain
// Description : Self-checking bench; a queue FIFO feeds the DUT and a waveform
//               schedule model predicts tx/tx_busy/tx_done/fifo_pop per cycle
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo_drain;

  localparam int c_DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] fifo_rdata;
  logic       fifo_empty;
  logic       fifo_pop;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  logic [7:0] fq[$];        // FIFO contents, head at index 0
  bit         exp_line[$];  // expected tx level for the current and future cycles
  int         errors = 0;
  int         checks = 0;

  uart_tx_fifo_drain #(
    .CLK_HZ (40),
    .BAUD   (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_rdata (fifo_rdata),
    .fifo_empty (fifo_empty),
    .fifo_pop   (fifo_pop),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
    end
  endtask

  // Schedule a whole 8N1 frame: start, 8 data bits LSB first, stop.
  task automatic push_frame(input logic [7:0] b);
    for (int i = 0; i < c_DIV; i++) exp_line.push_back(1'b0);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < c_DIV; i++) exp_line.push_back(b[k]);
    for (int i = 0; i < c_DIV; i++) exp_line.push_back(1'b1);
  endtask

  // One clock: drive FIFO outputs at negedge, check just after, advance the model.
  task automatic cycle();
    bit ep;
    bit et;
    bit eb;
    bit ed;
    @(negedge clk);
    fifo_empty = (fq.size() == 0);
    fifo_rdata = fifo_empty ? 8'($urandom) : fq[0];
    #1;
    if (rst) begin
      exp_line.delete();
      check("rst_tx",   tx,       1'b1);
      check("rst_busy", tx_busy,  1'b0);
      check("rst_done", tx_done,  1'b0);
      check("rst_pop",  fifo_pop, 1'b0);
    end else begin
      if (exp_line.size() == 0) begin
        et = 1'b1;
        eb = 1'b0;
        ed = 1'b0;
        ep = !fifo_empty;
      end else begin
        et = exp_line[0];
        eb = 1'b1;
        ed = (exp_line.size() == 1);
        ep = ed && !fifo_empty;
      end
      check("tx",      tx,       et);
      check("tx_busy", tx_busy,  eb);
      check("tx_done", tx_done,  ed);
      check("pop",     fifo_pop, ep);
      if (exp_line.size() != 0) void'(exp_line.pop_front());
      if (ep) push_frame(fq[0]);
      if (fifo_pop && fq.size() != 0) void'(fq.pop_front());
    end
  endtask

  initial begin
    rst        = 1'b1;
    fifo_empty = 1'b1;
    fifo_rdata = 8'h00;
    repeat (3) cycle();
    rst = 1'b0;

    // Idle hold
    repeat (200) cycle();

    // Single byte
    fq.push_back(8'h55);
    repeat (50) cycle();

    // Back-to-back preload
    fq.push_back(8'hA5);
    fq.push_back(8'h3C);
    repeat (90) cycle();

    // Late arrival during an ongoing frame
    fq.push_back(8'h11);
    repeat (10) cycle();
    fq.push_back(8'h22);
    repeat (80) cycle();

    // Reset during data bit 3 of 0x00
    fq.push_back(8'h00);
    repeat (18) cycle();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_tx",   tx,       1'b1);
    check("async_rst_busy", tx_busy,  1'b0);
    check("async_rst_pop",  fifo_pop, 1'b0);
    exp_line.delete();
    repeat (3) cycle();
    rst = 1'b0;
    repeat (20) cycle();

    // Extremes
    fq.push_back(8'h00);
    fq.push_back(8'hFF);
    repeat (90) cycle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0 && fq.size() < 4) fq.push_back(8'($urandom));
      cycle();
    end
    repeat (200) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_uart_tx_fifo_drain
`default_nettype wire
